cmd_stream_arbiter: RTL and testbench
=====================================

// Module: cmd_stream_arbiter
// PURPOSE
// - Shares the command parser's single AXIS command input between two command sources (0: host DMA, 1: display-list prefetcher).
// - Grants whole packets (a packet ends on the beat with tlast), so opcode/payload sequences are never interleaved.
// - Uses round-robin arbitration between the sources.
// - Sits directly upstream of the command parser's s_cmd_axis port; output is registered via a skid buffer.
// PARAMETERS
// - CMD_STREAM_WIDTH   16   data width of every stream port
// - CNT_WIDTH          16   width of per-port packet counters (only with CMD_ARB_PKT_CNT_EN)
// PORTS
// - aclk                  in   1     clock
// - resetn                in   1     reset, asynchronous, active-low
// - s0_cmd_axis_tvalid    in   1     source 0 beat valid
// - s0_cmd_axis_tready    out  1     source 0 beat accepted
// - s0_cmd_axis_tlast     in   1     source 0 end of packet
// - s0_cmd_axis_tdata     in   CMD_STREAM_WIDTH  source 0 data
// - s1_cmd_axis_*         (same four signals for source 1)
// - m_cmd_axis_tvalid     out  1     to command parser
// - m_cmd_axis_tready     in   1
// - m_cmd_axis_tlast      out  1
// - m_cmd_axis_tdata      out  CMD_STREAM_WIDTH
// - dbgArbState           out  2     {grant, busy}
// - pktCnt0, pktCnt1      out  CNT_WIDTH  completed packets per source (only with CMD_ARB_PKT_CNT_EN)
// BEHAVIOUR
// - Reset values: all tready 0, m_cmd_axis_tvalid/tlast 0, tdata 0, state IDLE, rrPtr 0 (source 0 preferred first), counters 0.
// - Reset asserted mid-packet aborts the packet. In-flight skid contents are discarded and m_cmd_axis_tvalid drops immediately.
// - FSM IDLE:
//   - If any sN_tvalid: pick a source. Only one valid -> that source. Both valid -> source rrPtr.
//   - Latch grant; go to BUSY. No beat is accepted in the IDLE cycle.
// - FSM BUSY:
//   - s{grant}_tready = skid.s_ready. The other source's tready = 0.
//   - A beat transfers when tvalid & tready.
//   - A transferred beat with tlast=1: rrPtr <= ~grant; go to IDLE.
//   - tvalid low mid-packet: hold grant indefinitely (no timeout, no preemption).
// - Overhead: 1 idle cycle per packet, from the last-beat accept to the next grant decision.
// - Skid buffer:
//   - 2 entries, full throughput while m_cmd_axis_tready=1.
//   - Latency 1 cycle from input accept to m_cmd_axis_tvalid.
//   - tdata/tlast stable while tvalid & !tready (AXIS rule).
//   - s_ready is registered and depends only on skid occupancy, never combinationally on m_cmd_axis_tready.
// - Downstream stall: skid fills (2 beats), then tready to the granted source drops next cycle. No beat is lost or duplicated.
// - Single-beat packet (tlast on first beat): legal; 1 transfer then IDLE.
// - tlast on a non-granted source is ignored until that source is granted.
// - Packet order is preserved per source; packets from both sources never interleave beats at m_cmd_axis.
// CONFIGURATION
// - CMD_ARB_PKT_CNT_EN defined:
//   - pktCnt0/pktCnt1 ports exist.
//   - The counter of the granted source increments by 1 on every accepted tlast beat; wraps 2^CNT_WIDTH-1 -> 0.
// - CMD_ARB_PKT_CNT_EN undefined: pktCnt ports and counter logic are absent. All other behaviour is identical.
// STRUCTURE
// - Shared package cmd_arb_pkg:
//   - localparams ARB_IDLE=1'b0, ARB_BUSY=1'b1.
//   - GRANT_S0=1'b0, GRANT_S1=1'b1.
//   - SKID_DEPTH=2.
// - Sub-module cmd_axis_skid (parameter WIDTH = CMD_STREAM_WIDTH+1): generic 2-entry AXIS register slice carrying {tlast,tdata}.
// - Top level holds only the FSM, grant/rrPtr registers, the input mux and the optional counters.
// TESTING
// - T1 single source: s0 sends 3-beat packet 0x1001,0x2002,0x3003(tlast), m_tready=1 -> m emits the same 3 beats in order, tlast on 0x3003; s1_tready stays 0.
// - T2 contention after reset: both valid, s0 pkt {0xA0,0xA1L}, s1 pkt {0xB0,0xB1L} -> output A0,A1L,B0,B1L.
//   - Repeat the same stimulus -> order A,B again (rrPtr alternates).
// - T3 backpressure: m_tready low 5 cycles during 8-beat s1 packet 0x0..0x7 -> exactly 8 beats 0x0..0x7 out; at most 2 accepted while stalled; tdata stable while stalled.
// - T4 idle mid-packet: s0 drops tvalid for 10 cycles after beat 2 of 4 while s1 is valid -> s1 receives no tready until s0's tlast beat is accepted.
// - T5 reset mid-packet: assert resetn=0 after 2 of 4 beats -> m_tvalid=0 and all tready=0 asynchronously; after release a fresh s1 packet passes intact.
// - T6 (CMD_ARB_PKT_CNT_EN): 3 s0 packets + 1 s1 packet -> pktCnt0=3, pktCnt1=1.
//   - Preload near wrap (force to 0xFFFF) + 1 packet -> 0.

Source files
------------

// File: rtl/cmd_arb_pkg.sv
// Shared definitions for the command stream arbiter.
//   ARB_IDLE/ARB_BUSY : arbiter FSM encodings
//   GRANT_S0/GRANT_S1 : grant encodings (0 = host DMA, 1 = display-list prefetcher)
//   SKID_DEPTH        : entries in the output register slice
package cmd_arb_pkg;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  localparam logic GRANT_S0 = 1'b0;
  localparam logic GRANT_S1 = 1'b1;

  localparam int unsigned SKID_DEPTH = 2;

  typedef enum logic {
    StIdle = ARB_IDLE,
    StBusy = ARB_BUSY
  } arb_state_e;

endpackage

// File: rtl/cmd_axis_skid.sv
// Two-entry AXIS register slice carrying {tlast, tdata}.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   s_valid_i/s_ready_o    : upstream handshake; s_ready_o is a flop driven only by occupancy
//   s_data_i               : upstream payload
//   m_valid_o/m_ready_i    : downstream handshake
//   m_data_o               : downstream payload, held stable while stalled
module cmd_axis_skid
  import cmd_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [CntW-1:0]  count_q, count_d;
  // One-bit pointers: the slice is exactly two entries deep.
  logic             wr_ptr_q, rd_ptr_q;
  logic             s_ready_q, s_ready_d;
  logic             push, pop;

  assign push      = s_valid_i & s_ready_q;
  assign pop       = (count_q != '0) & m_ready_i;
  assign s_ready_o = s_ready_q;
  assign m_valid_o = (count_q != '0);
  assign m_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d   = count_q + CntW'(push) - CntW'(pop);
    // Ready for the next cycle is decided from the occupancy we are about to have.
    s_ready_d = (count_d < CntW'(SKID_DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s_data_i;
      end
      wr_ptr_q  <= wr_ptr_q ^ push;
      rd_ptr_q  <= rd_ptr_q ^ pop;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
    end
  end

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Packet-level round-robin arbiter sharing the command parser's AXIS input between
// source 0 (host DMA) and source 1 (display-list prefetcher). Whole packets are granted
// (terminated by tlast); output is registered through cmd_axis_skid.
//   aclk, resetn           : clock, asynchronous active-low reset
//   s0_cmd_axis_*          : source 0 stream (tvalid, tready, tlast, tdata)
//   s1_cmd_axis_*          : source 1 stream
//   m_cmd_axis_*           : stream to the command parser
//   dbgArbState            : {grant, busy}
//   pktCnt0/pktCnt1        : completed packets per source (CMD_ARB_PKT_CNT_EN only)
// Build option: define CMD_ARB_PKT_CNT_EN to add the per-source packet counters.
module cmd_stream_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int unsigned CMD_STREAM_WIDTH = 16
`ifdef CMD_ARB_PKT_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic                        s0_cmd_axis_tvalid,
  output logic                        s0_cmd_axis_tready,
  input  logic                        s0_cmd_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s0_cmd_axis_tdata,
  input  logic                        s1_cmd_axis_tvalid,
  output logic                        s1_cmd_axis_tready,
  input  logic                        s1_cmd_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s1_cmd_axis_tdata,
  output logic                        m_cmd_axis_tvalid,
  input  logic                        m_cmd_axis_tready,
  output logic                        m_cmd_axis_tlast,
  output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
  output logic [1:0]                  dbgArbState
`ifdef CMD_ARB_PKT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]        pktCnt0,
  output logic [CNT_WIDTH-1:0]        pktCnt1
`endif
);

  arb_state_e state_q;
  logic       grant_q;
  logic       rr_q;

  logic                        busy;
  logic                        sel_valid;
  logic                        sel_last;
  logic [CMD_STREAM_WIDTH-1:0] sel_data;
  logic                        skid_s_ready;
  logic                        last_acc;

  assign busy = (state_q == StBusy);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    if (grant_q == GRANT_S1) begin
      sel_valid = busy & s1_cmd_axis_tvalid;
      sel_last  = s1_cmd_axis_tlast;
      sel_data  = s1_cmd_axis_tdata;
    end else begin
      sel_valid = busy & s0_cmd_axis_tvalid;
      sel_last  = s0_cmd_axis_tlast;
      sel_data  = s0_cmd_axis_tdata;
    end
  end

  // tready is built only from flops, so there is no path from m_cmd_axis_tready.
  assign s0_cmd_axis_tready = busy & (grant_q == GRANT_S0) & skid_s_ready;
  assign s1_cmd_axis_tready = busy & (grant_q == GRANT_S1) & skid_s_ready;
  assign last_acc           = sel_valid & skid_s_ready & sel_last;
  assign dbgArbState        = {grant_q, busy};

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= GRANT_S0;
      rr_q    <= GRANT_S0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // No beat moves in this cycle; it only decides the next owner.
          if (s0_cmd_axis_tvalid || s1_cmd_axis_tvalid) begin
            if (s0_cmd_axis_tvalid && s1_cmd_axis_tvalid) begin
              grant_q <= rr_q;
            end else begin
              grant_q <= s1_cmd_axis_tvalid ? GRANT_S1 : GRANT_S0;
            end
            state_q <= StBusy;
          end
        end
        StBusy: begin
          // Grant is held through any tvalid gaps until the tlast beat is taken.
          if (last_acc) begin
            rr_q    <= ~grant_q;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  cmd_axis_skid #(
    .WIDTH(CMD_STREAM_WIDTH + 1)
  ) u_skid (
    .clk_i    (aclk),
    .rst_ni   (resetn),
    .s_valid_i(sel_valid),
    .s_ready_o(skid_s_ready),
    .s_data_i ({sel_last, sel_data}),
    .m_valid_o(m_cmd_axis_tvalid),
    .m_ready_i(m_cmd_axis_tready),
    .m_data_o ({m_cmd_axis_tlast, m_cmd_axis_tdata})
  );

`ifdef CMD_ARB_PKT_CNT_EN
  logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt1_q;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else if (last_acc) begin
      if (grant_q == GRANT_S1) begin
        pkt_cnt1_q <= pkt_cnt1_q + CNT_WIDTH'(1);
      end else begin
        pkt_cnt0_q <= pkt_cnt0_q + CNT_WIDTH'(1);
      end
    end
  end

  assign pktCnt0 = pkt_cnt0_q;
  assign pktCnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Bench for cmd_stream_arbiter: queued expected beats per source, a packet-level
// round-robin model, and a negedge monitor that checks every output beat.
module tb_cmd_stream_arbiter;

  typedef struct packed {
    logic [7:0]  gap;
    logic        last;
    logic [15:0] data;
  } stim_t;

  logic        aclk = 1'b0;
  logic        resetn = 1'b1;
  logic        s0_tvalid = 1'b0, s0_tready, s0_tlast = 1'b0;
  logic [15:0] s0_tdata = '0;
  logic        s1_tvalid = 1'b0, s1_tready, s1_tlast = 1'b0;
  logic [15:0] s1_tdata = '0;
  logic        m_tvalid, m_tready = 1'b1, m_tlast;
  logic [15:0] m_tdata;
  logic [1:0]  dbg;
`ifdef CMD_ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

  cmd_stream_arbiter #(
    .CMD_STREAM_WIDTH(16)
  ) dut (
    .aclk              (aclk),
    .resetn            (resetn),
    .s0_cmd_axis_tvalid(s0_tvalid),
    .s0_cmd_axis_tready(s0_tready),
    .s0_cmd_axis_tlast (s0_tlast),
    .s0_cmd_axis_tdata (s0_tdata),
    .s1_cmd_axis_tvalid(s1_tvalid),
    .s1_cmd_axis_tready(s1_tready),
    .s1_cmd_axis_tlast (s1_tlast),
    .s1_cmd_axis_tdata (s1_tdata),
    .m_cmd_axis_tvalid (m_tvalid),
    .m_cmd_axis_tready (m_tready),
    .m_cmd_axis_tlast  (m_tlast),
    .m_cmd_axis_tdata  (m_tdata),
    .dbgArbState       (dbg)
`ifdef CMD_ARB_PKT_CNT_EN
    ,
    .pktCnt0           (pkt_cnt0),
    .pktCnt1           (pkt_cnt1)
`endif
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  stim_t       stim0[$], stim1[$];
  logic [16:0] exp0[$], exp1[$];
  int          pend0 = 0, pend1 = 0;   // packets queued but not yet started at the output
  bit          rr = 1'b0;              // model: source preferred on contention
  bit          in_pkt = 1'b0;
  int          cur_src = -1;
  int          mcnt0 = 0, mcnt1 = 0;
  bit          drv_busy0 = 0, drv_busy1 = 0;
  bit          open0 = 0, open1 = 0;
  bit          prev_stall = 0;
  logic [16:0] prev_beat = '0;
  bit          rand_rdy = 0;
  int          stall_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_beat(input int src, input logic [15:0] data, input logic last,
                          input int gap);
    stim_t s;
    s.gap  = 8'(gap);
    s.last = last;
    s.data = data;
    if (src == 0) begin
      stim0.push_back(s);
      exp0.push_back({last, data});
      if (last) pend0++;
    end else begin
      stim1.push_back(s);
      exp1.push_back({last, data});
      if (last) pend1++;
    end
  endtask

  task automatic add_rand_pkt(input int src);
    int len;
    len = $urandom_range(1, 5);
    for (int i = 0; i < len; i++) begin
      add_beat(src, {src[0], 15'($urandom)}, (i == len - 1),
               (i > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
  endtask

  task automatic set_src(input int src, input logic v, input logic l, input logic [15:0] d);
    if (src == 0) begin
      s0_tvalid = v; s0_tlast = l; s0_tdata = d;
    end else begin
      s1_tvalid = v; s1_tlast = l; s1_tdata = d;
    end
  endtask

  // Presents all queued beats of one source; called at posedge+1.
  task automatic drive(input int src);
    stim_t s;
    bit    hs;
    bit    quit;
    int    waits;
    quit = 0;
    if (src == 0) drv_busy0 = 1; else drv_busy1 = 1;
    while (!quit && ((src == 0) ? stim0.size() : stim1.size()) != 0) begin
      if (src == 0) s = stim0.pop_front(); else s = stim1.pop_front();
      if (s.gap != 0) begin
        set_src(src, 1'b0, 1'b0, 16'h0);
        repeat (int'(s.gap)) @(posedge aclk);
        #1;
      end
      set_src(src, 1'b1, s.last, s.data);
      hs = 0;
      waits = 0;
      while (!hs && !quit) begin
        @(negedge aclk);
        hs = (src == 0) ? (s0_tvalid && s0_tready) : (s1_tvalid && s1_tready);
        @(posedge aclk);
        #1;
        if (!hs) begin
          waits++;
          if (waits > 400) begin
            quit = 1;
            chk("drive_timeout", 32'(waits), 32'd0);
          end
        end
      end
      if (src == 0) open0 = !s.last; else open1 = !s.last;
    end
    set_src(src, 1'b0, 1'b0, 16'h0);
    if (src == 0) drv_busy0 = 0; else drv_busy1 = 0;
  endtask

  task automatic run_both();
    fork
      drive(0);
      drive(1);
    join
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || m_tvalid) && cyc < 500) begin
      @(posedge aclk);
      #1;
      cyc++;
    end
    chk("drain_timeout", 32'(cyc >= 500), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 0;
    repeat (2) @(posedge aclk);
    #1;
    resetn = 1;
    @(posedge aclk);
    #1;
  endtask

`ifdef CMD_ARB_PKT_CNT_EN
  task automatic chk_cnt();
    chk("pktCnt0", 32'(pkt_cnt0), 32'(mcnt0 & 'hFFFF));
    chk("pktCnt1", 32'(pkt_cnt1), 32'(mcnt1 & 'hFFFF));
  endtask
`endif

  // Output monitor and ownership checks, sampled at negedge.
  task automatic monitor_step();
    logic [16:0] e;
    if (!resetn) begin
      exp0.delete(); exp1.delete();
      pend0 = 0; pend1 = 0; rr = 0; in_pkt = 0; cur_src = -1;
      mcnt0 = 0; mcnt1 = 0; prev_stall = 0; open0 = 0; open1 = 0;
      return;
    end
    chk("tready_owner",
        32'({s0_tready && s1_tready, s0_tready && !drv_busy0, s1_tready && !drv_busy1,
             open0 && s1_tready, open1 && s0_tready}), 32'd0);
    if (prev_stall) chk("stall_hold", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, prev_beat}));
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = {m_tlast, m_tdata};
    if (!(m_tvalid && m_tready)) return;
    if (!in_pkt) begin
      if (pend0 > 0 && pend1 > 0) cur_src = int'(rr);
      else if (pend0 > 0) cur_src = 0;
      else if (pend1 > 0) cur_src = 1;
      else cur_src = -1;
      if (cur_src == 0) pend0--;
      if (cur_src == 1) pend1--;
      in_pkt = (cur_src >= 0);
    end
    if (cur_src < 0 || (cur_src == 0 ? exp0.size() : exp1.size()) == 0) begin
      chk("unexpected_beat", 32'({1'b1, m_tlast, m_tdata}), 32'd0);
      return;
    end
    e = (cur_src == 0) ? exp0.pop_front() : exp1.pop_front();
    chk((cur_src == 0) ? "beat_s0" : "beat_s1", 32'({m_tlast, m_tdata}), 32'(e));
    if (e[16]) begin
      in_pkt = 0;
      rr = (cur_src == 0);
      if (cur_src == 0) mcnt0++; else mcnt1++;
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge aclk);
        monitor_step();
      end
      forever begin
        @(posedge aclk);
        #1;
        if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
      end
      begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
      end
      begin
        // Reset state
        #3 resetn = 0;
        #1;
        chk("rst_s0_tready", 32'(s0_tready), 32'd0);
        chk("rst_s1_tready", 32'(s1_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_dbg", 32'(dbg), 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        resetn = 1;
        @(posedge aclk);
        #1;

        // T1: single source, 3-beat packet
        add_beat(0, 16'h1001, 1'b0, 0);
        add_beat(0, 16'h2002, 1'b0, 0);
        add_beat(0, 16'h3003, 1'b1, 0);
        run_both();
        drain();
        chk("t1_dbg_idle", 32'(dbg), 32'b00);

        // T2: contention right after reset, twice
        apply_reset();
        for (int r = 0; r < 2; r++) begin
          add_beat(0, 16'h00A0, 1'b0, 0);
          add_beat(0, 16'h00A1, 1'b1, 0);
          add_beat(1, 16'h00B0, 1'b0, 0);
          add_beat(1, 16'h00B1, 1'b1, 0);
          run_both();
          drain();
        end

        // T3: downstream stall during an 8-beat s1 packet
        for (int i = 0; i < 8; i++) add_beat(1, 16'(i), (i == 7), 0);
        m_tready = 1;
        stall_acc = 0;
        fork
          drive(1);
          begin
            repeat (3) @(posedge aclk);
            #1;
            m_tready = 0;
            repeat (5) begin
              @(negedge aclk);
              if (s1_tvalid && s1_tready) stall_acc++;
              @(posedge aclk);
              #1;
            end
            m_tready = 1;
          end
        join
        drain();
        chk("t3_stall_accepts_le2", 32'(stall_acc > 2), 32'd0);
        chk("t3_dbg_idle", 32'(dbg), 32'b10);

        // T4: s0 goes quiet mid-packet while s1 waits
        for (int i = 0; i < 4; i++) add_beat(0, 16'h4400 + 16'(i), (i == 3), (i == 2) ? 10 : 0);
        add_beat(1, 16'h8800, 1'b0, 0);
        add_beat(1, 16'h8801, 1'b1, 0);
        run_both();
        drain();

        // T5: reset in the middle of a packet
        begin
          int idx, waits;
          bit hs;
          logic [15:0] t5d[4];
          for (int i = 0; i < 4; i++) begin
            t5d[i] = 16'h5000 + 16'(i);
            add_beat(0, t5d[i], (i == 3), 0);
          end
          stim0.delete();
          drv_busy0 = 1;
          idx = 0;
          waits = 0;
          set_src(0, 1'b1, 1'b0, t5d[0]);
          while (idx < 2 && waits < 100) begin
            @(negedge aclk);
            hs = s0_tvalid && s0_tready;
            @(posedge aclk);
            #1;
            if (hs) begin
              idx++;
              set_src(0, 1'b1, (idx == 3), t5d[idx]);
            end else begin
              waits++;
            end
          end
          chk("t5_progress", 32'(idx), 32'd2);
          chk("t5_m_tvalid_before", 32'(m_tvalid), 32'd1);
          #2 resetn = 0;
          #1;
          chk("t5_m_tvalid", 32'(m_tvalid), 32'd0);
          chk("t5_s0_tready", 32'(s0_tready), 32'd0);
          chk("t5_s1_tready", 32'(s1_tready), 32'd0);
          set_src(0, 1'b0, 1'b0, 16'h0);
          drv_busy0 = 0;
          repeat (3) @(posedge aclk);
          #1;
          resetn = 1;
          @(posedge aclk);
          #1;
          add_beat(1, 16'hC000, 1'b0, 0);
          add_beat(1, 16'hC001, 1'b0, 0);
          add_beat(1, 16'hC002, 1'b1, 0);
          run_both();
          drain();
        end

`ifdef CMD_ARB_PKT_CNT_EN
        // T6: packet counters and wrap
        apply_reset();
        for (int p = 0; p < 3; p++) add_rand_pkt(0);
        add_rand_pkt(1);
        run_both();
        drain();
        chk("t6_cnt0_eq3", 32'(pkt_cnt0), 32'd3);
        chk("t6_cnt1_eq1", 32'(pkt_cnt1), 32'd1);
        force dut.pkt_cnt0_q = 16'hFFFF;
        @(negedge aclk);
        release dut.pkt_cnt0_q;
        @(posedge aclk);
        #1;
        mcnt0 = 'hFFFF;
        add_beat(0, 16'h0F0F, 1'b1, 0);
        run_both();
        drain();
        chk("t6_wrap", 32'(pkt_cnt0), 32'd0);
`endif

        // Randomized rounds with random downstream backpressure
        rand_rdy = 1;
        for (int r = 0; r < 30; r++) begin
          int n0, n1;
          n0 = $urandom_range(0, 3);
          n1 = $urandom_range(0, 3);
          for (int p = 0; p < n0; p++) add_rand_pkt(0);
          for (int p = 0; p < n1; p++) add_rand_pkt(1);
          run_both();
          drain();
`ifdef CMD_ARB_PKT_CNT_EN
          chk_cnt();
`endif
        end
        rand_rdy = 0;
        m_tready = 1;
        repeat (2) @(posedge aclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    join
  end

endmodule
